// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler for the async FIFO: buffers one RF byte and one ALU word,
// arbitrates between them round-robin and serialises the ALU word LSB first.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic                  RF_RDY,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_VLD,
    output logic                  ALU_RDY,
    input  logic                  FULL,
    output logic                  W_INC,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  BUSY,
    output logic                  DROP_ERR
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WR_RF     = 2'd1;
    localparam logic [1:0] ST_WR_ALU_LO = 2'd2;
    localparam logic [1:0] ST_WR_ALU_HI = 2'd3;

    localparam logic GNT_RF  = 1'b0;
    localparam logic GNT_ALU = 1'b1;

    logic [1:0]            state_q,      state_d;
    logic                  rf_pend_q,    rf_pend_d;
    logic                  alu_pend_q,   alu_pend_d;
    logic [DATA_WIDTH-1:0] rf_buf_q,     rf_buf_d;
    logic [ALU_WIDTH-1:0]  alu_buf_q,    alu_buf_d;
    logic                  last_grant_q, last_grant_d;
    logic                  drop_err_q,   drop_err_d;

    logic                  in_write;

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // through the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        rf_pend_d    = rf_pend_q;
        alu_pend_d   = alu_pend_q;
        rf_buf_d     = rf_buf_q;
        alu_buf_d    = alu_buf_q;
        last_grant_d = last_grant_q;

        // Capture only into a free buffer; a buffer being released this cycle still
        // reads as pending, so capture and release never coincide.
        if (RF_RD_VLD && !rf_pend_q) begin
            rf_buf_d  = RF_RD_DATA;
            rf_pend_d = 1'b1;
        end
        if (ALU_VLD && !alu_pend_q) begin
            alu_buf_d  = ALU_OUT;
            alu_pend_d = 1'b1;
        end
        drop_err_d = (RF_RD_VLD && rf_pend_q) || (ALU_VLD && alu_pend_q);

        case (state_q)
            ST_IDLE: begin
                // Only a contended grant moves the round-robin pointer.
                if (rf_pend_q && alu_pend_q) begin
                    if (last_grant_q == GNT_ALU) begin
                        state_d      = ST_WR_RF;
                        last_grant_d = GNT_RF;
                    end else begin
                        state_d      = ST_WR_ALU_LO;
                        last_grant_d = GNT_ALU;
                    end
                end else if (rf_pend_q) begin
                    state_d = ST_WR_RF;
                end else if (alu_pend_q) begin
                    state_d = ST_WR_ALU_LO;
                end
            end
            ST_WR_RF: begin
                if (!FULL) begin
                    rf_pend_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_ALU_LO: begin
                if (!FULL) begin
                    state_d = ST_WR_ALU_HI;
                end
            end
            ST_WR_ALU_HI: begin
                if (!FULL) begin
                    alu_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write presented while reset is asserted would carry discarded data.
    assign in_write = (state_q != ST_IDLE);
    assign W_INC    = RST && in_write && !FULL;

    always_comb begin
        WR_DATA = '0;
        case (state_q)
            ST_WR_RF:     WR_DATA = rf_buf_q;
            ST_WR_ALU_LO: WR_DATA = alu_buf_q[DATA_WIDTH-1:0];
            ST_WR_ALU_HI: WR_DATA = alu_buf_q[ALU_WIDTH-1:DATA_WIDTH];
            default:      WR_DATA = '0;
        endcase
    end

    assign RF_RDY   = !rf_pend_q;
    assign ALU_RDY  = !alu_pend_q;
    assign BUSY     = in_write || rf_pend_q || alu_pend_q;
    assign DROP_ERR = drop_err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            rf_pend_q    <= 1'b0;
            alu_pend_q   <= 1'b0;
            rf_buf_q     <= '0;
            alu_buf_q    <= '0;
            last_grant_q <= GNT_ALU;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_pend_q    <= rf_pend_d;
            alu_pend_q   <= alu_pend_d;
            rf_buf_q     <= rf_buf_d;
            alu_buf_q    <= alu_buf_d;
            last_grant_q <= last_grant_d;
            drop_err_q   <= drop_err_d;
        end
    end

endmodule
